// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the two-requester shared adder: FSM encoding,
// requester count and default datapath width.
package adder_share_arbiter_pkg;

   localparam int NUM_REQ       = 2;
   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/adder_share_arbiter_shared_adder.sv
// Combinational WIDTH-bit adder with carry-out. A single copy is shared
// by both requesters.
module shared_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             carry
);

   logic [WIDTH:0] full;

   assign full  = {1'b0, a} + {1'b0, b};
   assign sum   = full[WIDTH-1:0];
   assign carry = full[WIDTH];

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one adder between two requesters.
// Each requester also owns an accumulator for running sums.
module adder_share_arbiter
   import adder_share_arbiter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic [NUM_REQ-1:0]   req_acc,
   input  logic [WIDTH-1:0]     req_a0,
   input  logic [WIDTH-1:0]     req_b0,
   input  logic [WIDTH-1:0]     req_a1,
   input  logic [WIDTH-1:0]     req_b1,
   output logic [NUM_REQ-1:0]   rsp_valid,
   input  logic [NUM_REQ-1:0]   rsp_ready,
   output logic [WIDTH-1:0]     rsp_sum,
   output logic                 rsp_carry,
   output logic                 busy
);

   state_t state, state_nxt;

   logic                            last_grant;
   logic                            gnt;
   logic                            gnt_sel;
   logic                            grant_en;
   logic [WIDTH-1:0]                op_a;
   logic [WIDTH-1:0]                op_b;
   logic                            op_acc;
   logic [NUM_REQ-1:0][WIDTH-1:0]   acc;

   logic [WIDTH-1:0]                add_b;
   logic [WIDTH-1:0]                add_sum;
   logic                            add_carry;

   // Captured operands feed the adder, so rsp_* never sees req_* combinationally.
   assign add_b = op_acc ? acc[gnt] : op_b;

   shared_adder #(.WIDTH(WIDTH)) u_adder (
      .a     (op_a),
      .b     (add_b),
      .sum   (add_sum),
      .carry (add_carry)
   );

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      gnt_sel   = 1'b0;
      grant_en  = 1'b0;
      case (state)
         IDLE: begin
            if (|req_valid) begin
               grant_en = 1'b1;
               // Under contention the requester not served last time wins.
               gnt_sel  = (&req_valid) ? ~last_grant : req_valid[1];
               req_ready[gnt_sel] = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            rsp_valid[gnt] = 1'b1;
            if (rsp_ready[gnt]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_acc     <= 1'b0;
         acc        <= '0;
         rsp_sum    <= '0;
         rsp_carry  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         if (grant_en) begin
            gnt    <= gnt_sel;
            op_a   <= gnt_sel ? req_a1 : req_a0;
            op_b   <= gnt_sel ? req_b1 : req_b0;
            op_acc <= req_acc[gnt_sel];
         end
         if (state == EXEC) begin
            rsp_sum    <= add_sum;
            rsp_carry  <= add_carry;
            last_grant <= gnt;
            // Carry is reported but the accumulator wraps.
            if (op_acc) acc[gnt] <= add_sum;
         end
      end
   end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: accepted requests push expected
// results, response handshakes pop and compare.
module tb_adder_share_arbiter;

   logic       clk;
   logic       rst;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [1:0] req_acc;
   logic [7:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0] rsp_valid;
   logic [1:0] rsp_ready;
   logic [7:0] rsp_sum;
   logic       rsp_carry;
   logic       busy;

   int vectors = 0;
   int errors  = 0;

   typedef struct {
      int         id;
      logic [7:0] sum;
      logic       carry;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] m_acc [2];
   logic       m_last;

   adder_share_arbiter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_acc   (req_acc),
      .req_a0    (req_a0),
      .req_b0    (req_b0),
      .req_a1    (req_a1),
      .req_b1    (req_b1),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_carry (rsp_carry),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: flushed by reset, updated at acceptance, checked at handshake.
   initial begin
      m_acc[0] = '0;
      m_acc[1] = '0;
      m_last   = 1'b1;
   end

   always @(posedge rst) begin
      sb.delete();
      m_acc[0] = '0;
      m_acc[1] = '0;
      m_last   = 1'b1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (req_ready != 2'b00) begin
            int         g;
            logic [1:0] exp_rdy;
            logic [8:0] full;
            exp_t       e;
            if (req_valid == 2'b11) g = m_last ? 0 : 1;
            else                    g = req_valid[1] ? 1 : 0;
            exp_rdy = 2'b01 << g;
            vectors++;
            if (req_ready !== exp_rdy) begin
               errors++;
               $display("FAIL grant: req_ready=%b expected %b", req_ready, exp_rdy);
            end
            if (g == 0) full = {1'b0, req_a0} + {1'b0, req_acc[0] ? m_acc[0] : req_b0};
            else        full = {1'b0, req_a1} + {1'b0, req_acc[1] ? m_acc[1] : req_b1};
            if (req_acc[g]) m_acc[g] = full[7:0];
            m_last  = g[0];
            e.id    = g;
            e.sum   = full[7:0];
            e.carry = full[8];
            sb.push_back(e);
         end
         for (int g = 0; g < 2; g++) begin
            if (rsp_valid[g] && rsp_ready[g]) begin
               vectors++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rsp: requester %0d sum=%h with empty scoreboard", g, rsp_sum);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  if (e.id != g || rsp_sum !== e.sum || rsp_carry !== e.carry) begin
                     errors++;
                     $display("FAIL scoreboard: got id=%0d sum=%h carry=%b expected id=%0d sum=%h carry=%b",
                              g, rsp_sum, rsp_carry, e.id, e.sum, e.carry);
                  end
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request, waits for acceptance, returns during the RESP cycle.
   task automatic issue(input int id, input logic acc, input logic [7:0] a, input logic [7:0] b);
      bit         got;
      logic [1:0] exp_v;
      got   = 0;
      exp_v = 2'b01 << id;
      req_acc[id] = acc;
      if (id == 0) begin req_a0 = a; req_b0 = b; end
      else         begin req_a1 = a; req_b1 = b; end
      req_valid[id] = 1'b1;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (req_ready[id]) got = 1;
         else tick();
      end
      vectors++;
      if (!got) begin
         errors++;
         $display("FAIL accept_timeout: requester %0d req_ready=%b expected bit set", id, req_ready);
         req_valid[id] = 1'b0;
         return;
      end
      tick();
      req_valid[id] = 1'b0;
      tick();
      vectors++;
      if (rsp_valid !== exp_v || busy !== 1'b1) begin
         errors++;
         $display("FAIL latency: rsp_valid=%b busy=%b expected rsp_valid=%b busy=1", rsp_valid, busy, exp_v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '0; req_acc = '0; rsp_ready = 2'b11;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      #12;
      vectors++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_sum !== 8'h00 || rsp_carry !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b sum=%h c=%b busy=%b expected all zero",
                  req_ready, rsp_valid, rsp_sum, rsp_carry, busy);
      end
      #5 rst = 1'b0;
      tick();
   endtask

   task automatic test_plain_add();
      issue(0, 1'b0, 8'h12, 8'h34);
      vectors++;
      if (rsp_sum !== 8'h46 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL plain_add: sum=%h carry=%b expected 46/0", rsp_sum, rsp_carry);
      end
      tick();
      vectors++;
      if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
         errors++;
         $display("FAIL plain_idle: busy=%b rsp_valid=%b expected 0/00", busy, rsp_valid);
      end
   endtask

   task automatic test_overflow();
      issue(1, 1'b0, 8'hFF, 8'h01);
      vectors++;
      if (rsp_sum !== 8'h00 || rsp_carry !== 1'b1) begin
         errors++;
         $display("FAIL overflow: sum=%h carry=%b expected 00/1", rsp_sum, rsp_carry);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] grants [4];
      int         cyc    [4];
      int         n;
      logic [1:0] exp_g;
      n = 0;
      req_acc = 2'b00;
      req_a0 = 8'h01; req_b0 = 8'h02; req_a1 = 8'h03; req_b1 = 8'h04;
      req_valid = 2'b11;
      for (int c = 0; c < 20 && n < 4; c++) begin
         #1;
         if (req_ready != 2'b00) begin
            grants[n] = req_ready;
            cyc[n]    = c;
            n++;
         end
         tick();
      end
      req_valid = 2'b00;
      vectors++;
      if (n != 4) begin
         errors++;
         $display("FAIL b2b_count: grants=%0d expected 4", n);
      end else begin
         for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (grants[i] !== exp_g) begin
               errors++;
               $display("FAIL b2b_order: grant %0d=%b expected %b", i, grants[i], exp_g);
            end
            if (i > 0) begin
               vectors++;
               if (cyc[i] - cyc[i-1] != 3) begin
                  errors++;
                  $display("FAIL b2b_spacing: gap %0d expected 3", cyc[i] - cyc[i-1]);
               end
            end
         end
      end
      tick(); tick(); tick();
   endtask

   task automatic test_accumulate();
      logic [7:0] av [3] = '{8'h80, 8'h90, 8'h01};
      logic [7:0] sv [3] = '{8'h80, 8'h10, 8'h11};
      logic       cv [3] = '{1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 3; i++) begin
         issue(0, 1'b1, av[i], 8'hAA);
         vectors++;
         if (rsp_sum !== sv[i] || rsp_carry !== cv[i]) begin
            errors++;
            $display("FAIL accumulate[%0d]: sum=%h carry=%b expected %h/%b", i, rsp_sum, rsp_carry, sv[i], cv[i]);
         end
         tick();
      end
      issue(1, 1'b1, 8'h05, 8'hAA);
      vectors++;
      if (rsp_sum !== 8'h05 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL acc1_untouched: sum=%h carry=%b expected 05/0", rsp_sum, rsp_carry);
      end
      tick();
      req_acc = 2'b00;
   endtask

   task automatic test_backpressure();
      rsp_ready = 2'b10;
      issue(0, 1'b0, 8'h10, 8'h20);
      req_acc[1] = 1'b0; req_a1 = 8'h05; req_b1 = 8'h06;
      req_valid[1] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++;
         if (rsp_valid !== 2'b01 || rsp_sum !== 8'h30 || rsp_carry !== 1'b0 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL backpressure[%0d]: vld=%b sum=%h c=%b rdy=%b expected 01/30/0/00",
                     i, rsp_valid, rsp_sum, rsp_carry, req_ready);
         end
         tick();
      end
      rsp_ready = 2'b11;
      tick();
      #1;
      vectors++;
      if (req_ready !== 2'b10) begin
         errors++;
         $display("FAIL bp_regrant: req_ready=%b expected 10", req_ready);
      end
      tick();
      req_valid[1] = 1'b0;
      tick();
      vectors++;
      if (rsp_valid !== 2'b10 || rsp_sum !== 8'h0B) begin
         errors++;
         $display("FAIL bp_second: vld=%b sum=%h expected 10/0b", rsp_valid, rsp_sum);
      end
      tick();
   endtask

   task automatic test_reset_mid_exec();
      req_acc[0] = 1'b1; req_a0 = 8'h07;
      req_valid[0] = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rst_setup: req_ready=%b expected 01", req_ready);
      end
      tick();
      req_valid[0] = 1'b0;
      #2 rst = 1'b1;
      #1;
      vectors++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_sum !== 8'h00 || rsp_carry !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: rdy=%b vld=%b sum=%h c=%b busy=%b expected all zero",
                  req_ready, rsp_valid, rsp_sum, rsp_carry, busy);
      end
      #2 rst = 1'b0;
      tick();
      req_acc = 2'b01; req_a0 = 8'h05; req_a1 = 8'h01; req_b1 = 8'h01;
      req_valid = 2'b11;
      #1;
      vectors++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL rst_first_grant: req_ready=%b expected 01", req_ready);
      end
      tick();
      req_valid = 2'b00;
      tick();
      vectors++;
      if (rsp_valid !== 2'b01 || rsp_sum !== 8'h05 || rsp_carry !== 1'b0) begin
         errors++;
         $display("FAIL rst_acc_cleared: vld=%b sum=%h c=%b expected 01/05/0", rsp_valid, rsp_sum, rsp_carry);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_plain_add();
      test_overflow();
      test_back_to_back();
      test_accumulate();
      test_backpressure();
      test_reset_mid_exec();
      tick(); tick();
      vectors++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one WIDTH-bit adder datapath (sum of two operands) between two independent requesters.
- Round-robin arbitration, valid/ready request handshake, registered result with valid/ready response handshake.
- Per-requester accumulator registers enable running-sum operation.
- Sits between the pin-level input muxing and the output drivers; the top level instantiates it in place of a bare combinational adder.

Parameters:
- WIDTH, 8, operand/result width in bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  2  bit i: requester i presents an operation
- req_ready  output  2  bit i: requester i's operation accepted this cycle
- req_acc  input  2  bit i: 1 = accumulate (acc_i + a_i), 0 = plain add (a_i + b_i)
- req_a0  input  WIDTH  operand A, requester 0
- req_b0  input  WIDTH  operand B, requester 0
- req_a1  input  WIDTH  operand A, requester 1
- req_b1  input  WIDTH  operand B, requester 1
- rsp_valid  output  2  bit i: result for requester i is valid
- rsp_ready  input  2  bit i: requester i consumes the result
- rsp_sum  output  WIDTH  registered sum, meaningful when either rsp_valid bit is set
- rsp_carry  output  1  carry-out of the same operation
- busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: state IDLE; req_ready=0; rsp_valid=0; rsp_sum=0; rsp_carry=0; busy=0; acc0=acc1=0; last_grant=1, so requester 0 wins the first contest.
- FSM states: IDLE, EXEC, RESP.
- IDLE arbitration:
  - one valid request: that requester is granted.
  - both valid: the requester other than last_grant is granted.
- IDLE grant actions:
  - req_ready[g]=1 combinationally in the same cycle (the only state in which req_ready can be 1).
  - operands, req_acc[g] and g are captured into registers.
  - next state EXEC.
- req_valid is not required to hold after acceptance. Before acceptance, requesters must hold valid and operands stable.
- EXEC:
  - {carry,sum} = opA + (acc_op ? acc_g : opB), computed at WIDTH+1 bits.
  - result registered into rsp_sum/rsp_carry.
  - if acc_op, acc_g <= sum, wrapping mod 2^WIDTH; the carry is reported but not stored.
  - last_grant <= g; next state RESP.
- RESP:
  - rsp_valid[g]=1; rsp_sum and rsp_carry are held stable.
  - on rsp_ready[g], return to IDLE next cycle. The other bit of rsp_ready is ignored.
  - new requests stall while in RESP (req_ready=0).
- Latency: accept at cycle T, rsp_valid at T+2. Minimum of 3 cycles per operation, with a handshake in the same cycle as rsp_valid rising.
- Back-to-back: with both requesters continuously valid, grants alternate 0,1,0,1.
- Fairness: a requester that deasserts valid loses nothing; the pointer advances only on an actual grant.
- Wrap: 8'hFF + 8'h01 gives sum 8'h00, carry 1.
- Reset asserted mid-operation: immediate return to reset values; any in-flight result is discarded, and the accumulator update is lost if not yet committed.
- The only outputs driven combinationally from state are req_ready and rsp_valid. No combinational path from req_* inputs to rsp_* outputs.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, EXEC, RESP).
  - NUM_REQ=2 constant.
  - default WIDTH constant.
- One sub-module: shared_adder.
  - Purely combinational WIDTH-bit adder with carry-out.
  - Instantiated once; the arbiter muxes its operands.
  - The top-level sum example is rewired to reuse it.

Test Plan:
- Single plain add: req0 a=8'h12 b=8'h34, acc=0 -> req_ready[0] same cycle; rsp_valid[0] two cycles later; rsp_sum=8'h46, carry=0; busy high throughout.
- Overflow: req1 a=8'hFF b=8'h01 -> rsp_sum=8'h00, rsp_carry=1, rsp_valid[1] only.
- Contention fairness: both valid continuously for 4 ops with rsp_ready tied high -> grant order 0,1,0,1, each 3 cycles apart.
- Accumulate: req0 acc=1 with a=8'h80, then a=8'h90, then a=8'h01 -> sums 8'h80, 8'h10 (carry 1), 8'h11. acc1 remains 0.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles after the result -> rsp_valid/sum stable; req_ready stays 0 despite req1 valid; req1 granted in the cycle after the handshake.
- Async reset during EXEC: assert rst between clock edges -> all outputs 0 immediately, state IDLE, acc cleared; the next request from 0 and 1 together is granted to requester 0.
